// File: rtl/auto_player.sv
// Automated opponent: scans a board snapshot for win/block/centre/corner/edge,
// strobes one move into the chip and waits for the board to acknowledge it.
module auto_player #(
    parameter logic [1:0]  MY_MARK     = 2'b10,
    parameter logic [1:0]  OPP_MARK    = 2'b01,
    parameter logic [2:0]  TURN_STATE  = 3'd2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        enable,
    input  logic [17:0] gBoard,
    input  logic [2:0]  gameState,
    output logic [3:0]  playerInput,
    output logic        playerWrite,
    output logic        busy,
    output logic        moveErr
);

    localparam int unsigned CW = $clog2(ACK_TIMEOUT);
    // Fallback preference, first entry in the low nibble: centre, corners, edges.
    localparam logic [35:0] PICK_ORDER = {4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};

    typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, PICK, ISSUE, WAIT_ACK} state_t;

    state_t        state, nextState;
    logic [17:0]   snapshot, nextSnapshot;
    logic [2:0]    line, nextLine;
    logic [3:0]    target, nextTarget;
    logic [CW-1:0] ackCount, nextAckCount;
    logic          nextErr;
    logic          turn;
    logic [3:0]    c0, c1, c2;
    logic [1:0]    scanMark;
    logic [4:0]    hit;
    logic          pickFound;
    logic [3:0]    pickCell;

    function automatic logic [1:0] cellOf(input logic [17:0] b, input logic [3:0] idx);
        cellOf = 2'b11;
        for (int unsigned i = 0; i < 9; i++)
            if (idx == 4'(i)) cellOf = b[2*i +: 2];
    endfunction

    // Returns {hit, emptyCell}; a cell equal to 00 can never equal a mark.
    function automatic logic [4:0] lineHit(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c, input logic [3:0] ia,
                                           input logic [3:0] ib, input logic [3:0] ic,
                                           input logic [1:0] mark);
        lineHit = '0;
        if (a == mark && b == mark && c == 2'b00)      lineHit = {1'b1, ic};
        else if (a == mark && c == mark && b == 2'b00) lineHit = {1'b1, ib};
        else if (b == mark && c == mark && a == 2'b00) lineHit = {1'b1, ia};
    endfunction

    always_comb begin
        c0 = 4'd0; c1 = 4'd1; c2 = 4'd2;
        case (line)
            3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
            3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
            3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
            3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
            3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
            3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
            3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
            default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
        endcase
    end

    always_comb begin
        pickFound = 1'b0;
        pickCell  = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (!pickFound && cellOf(snapshot, PICK_ORDER[4*i +: 4]) == 2'b00) begin
                pickFound = 1'b1;
                pickCell  = PICK_ORDER[4*i +: 4];
            end
        end
    end

    always_comb begin
        turn     = enable && (gameState == TURN_STATE);
        scanMark = (state == SCAN_BLOCK) ? OPP_MARK : MY_MARK;
        hit      = lineHit(cellOf(snapshot, c0), cellOf(snapshot, c1), cellOf(snapshot, c2),
                           c0, c1, c2, scanMark);

        nextState    = state;
        nextSnapshot = snapshot;
        nextLine     = line;
        nextTarget   = target;
        nextAckCount = ackCount;
        nextErr      = 1'b0;

        case (state)
            IDLE: begin
                if (turn) begin
                    nextSnapshot = gBoard;
                    nextLine     = '0;
                    nextState    = SCAN_WIN;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (!turn) begin
                    nextState = IDLE;
                end else if (hit[4]) begin
                    nextTarget = hit[3:0];
                    nextState  = ISSUE;
                end else if (line == 3'd7) begin
                    nextLine  = '0;
                    nextState = (state == SCAN_WIN) ? SCAN_BLOCK : PICK;
                end else begin
                    nextLine = line + 3'd1;
                end
            end
            PICK: begin
                if (turn && pickFound) begin
                    nextTarget = pickCell;
                    nextState  = ISSUE;
                end else begin
                    nextState = IDLE;
                end
            end
            ISSUE: begin
                nextAckCount = '0;
                nextState    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (cellOf(gBoard, target) != 2'b00 || gameState != TURN_STATE) begin
                    nextState = IDLE;
                end else if (ackCount == CW'(ACK_TIMEOUT - 1)) begin
                    nextErr   = 1'b1;
                    nextState = IDLE;
                end else begin
                    nextAckCount = ackCount + CW'(1);
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state       <= IDLE;
            snapshot    <= '0;
            line        <= '0;
            target      <= '0;
            ackCount    <= '0;
            playerInput <= '0;
            playerWrite <= 1'b0;
            busy        <= 1'b0;
            moveErr     <= 1'b0;
        end else begin
            state       <= nextState;
            snapshot    <= nextSnapshot;
            line        <= nextLine;
            target      <= nextTarget;
            ackCount    <= nextAckCount;
            playerWrite <= (state == ISSUE);
            if (state == ISSUE) playerInput <= target;
            busy        <= (state != IDLE);
            moveErr     <= nextErr;
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player: move priority, latency, timeout and abort paths.
module tb_auto_player;

    localparam logic [1:0] MY   = 2'b10;
    localparam logic [1:0] OPP  = 2'b01;
    localparam logic [2:0] TURN = 3'd2;
    localparam int         TMO  = 16;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [17:0] gBoard = '0;
    logic [2:0]  gameState = 3'd0;
    logic [3:0]  playerInput;
    logic        playerWrite, busy, moveErr;

    int checks = 0;
    int errors = 0;

    int          wrCyc, wrCount;
    logic [3:0]  wrCell;
    logic        busyLog [64];
    logic        errLog  [64];

    auto_player #(.MY_MARK(MY), .OPP_MARK(OPP), .TURN_STATE(TURN), .ACK_TIMEOUT(TMO)) dut (
        .ph1(ph1), .reset(reset), .enable(enable), .gBoard(gBoard), .gameState(gameState),
        .playerInput(playerInput), .playerWrite(playerWrite), .busy(busy), .moveErr(moveErr)
    );

    always #5 ph1 = ~ph1;

    function automatic logic [17:0] setCell(input logic [17:0] b, input int idx, input logic [1:0] v);
        logic [17:0] r;
        r = b;
        r[2*idx +: 2] = v;
        return r;
    endfunction

    // Presents a turn; sample index c is the cycle following edge c (edge 0 samples the turn).
    task automatic runTurn(input logic [17:0] b, input int ncyc, input bit ack, input int dropAt);
        @(negedge ph1);
        gBoard = b; gameState = TURN; enable = 1'b1;
        wrCyc = -1; wrCount = 0; wrCell = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge ph1);
            busyLog[c] = busy;
            errLog[c]  = moveErr;
            if (playerWrite) begin
                wrCount++;
                if (wrCyc < 0) begin wrCyc = c; wrCell = playerInput; end
                if (ack) begin
                    gBoard[2*int'(playerInput) +: 2] = MY;
                    gameState = 3'd0;
                end
            end
            if (c == dropAt) gameState = 3'd0;
        end
        gameState = 3'd0;
        repeat (3) @(negedge ph1);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge ph1);
        checks++; if (playerWrite !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", playerWrite); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (moveErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", moveErr); end
        checks++; if (playerInput !== 4'd0) begin errors++; $display("FAIL reset_input got %0d want 0", playerInput); end
        reset = 1'b0;
        @(negedge ph1);
    endtask

    task automatic test_empty_centre;
        runTurn('0, 22, 1'b1, -1);
        checks++; if (wrCyc !== 18) begin errors++; $display("FAIL centre_cycle got %0d want 18", wrCyc); end
        checks++; if (wrCell !== 4'd4) begin errors++; $display("FAIL centre_cell got %0d want 4", wrCell); end
        checks++; if (wrCount !== 1) begin errors++; $display("FAIL centre_count got %0d want 1", wrCount); end
        checks++; if (busyLog[17] !== 1'b1) begin errors++; $display("FAIL centre_busy17 got %b want 1", busyLog[17]); end
        checks++; if (busyLog[20] !== 1'b0) begin errors++; $display("FAIL centre_busy_after_ack got %b want 0", busyLog[20]); end
    endtask

    task automatic test_win_block;
        logic [17:0] b;
        b = setCell(setCell('0, 0, MY), 1, MY);
        runTurn(b, 8, 1'b1, -1);
        checks++; if (wrCyc !== 2) begin errors++; $display("FAIL win_cycle got %0d want 2", wrCyc); end
        checks++; if (wrCell !== 4'd2) begin errors++; $display("FAIL win_cell got %0d want 2", wrCell); end
        b = setCell(setCell('0, 3, OPP), 4, OPP);
        runTurn(b, 14, 1'b1, -1);
        checks++; if (wrCyc !== 11) begin errors++; $display("FAIL block_cycle got %0d want 11", wrCyc); end
        checks++; if (wrCell !== 4'd5) begin errors++; $display("FAIL block_cell got %0d want 5", wrCell); end
    endtask

    task automatic test_priority;
        logic [17:0] b;
        b = setCell(setCell(setCell(setCell('0, 6, MY), 7, MY), 0, OPP), 1, OPP);
        runTurn(b, 8, 1'b1, -1);
        checks++; if (wrCyc !== 4) begin errors++; $display("FAIL prio_cycle got %0d want 4", wrCyc); end
        checks++; if (wrCell !== 4'd8) begin errors++; $display("FAIL prio_cell got %0d want 8", wrCell); end
    endtask

    task automatic test_pick_fallbacks;
        logic [17:0] b;
        b = setCell('0, 4, OPP);
        runTurn(b, 21, 1'b1, -1);
        checks++; if (wrCyc !== 18) begin errors++; $display("FAIL corner_cycle got %0d want 18", wrCyc); end
        checks++; if (wrCell !== 4'd0) begin errors++; $display("FAIL corner_cell got %0d want 0", wrCell); end
        // Centre invalid (11), corners filled so that no line holds a pair.
        b = setCell(setCell(setCell(setCell(setCell('0, 4, 2'b11), 0, MY), 2, OPP), 6, OPP), 8, MY);
        runTurn(b, 21, 1'b1, -1);
        checks++; if (wrCyc !== 18) begin errors++; $display("FAIL edge_cycle got %0d want 18", wrCyc); end
        checks++; if (wrCell !== 4'd1) begin errors++; $display("FAIL edge_cell got %0d want 1", wrCell); end
    endtask

    task automatic test_full_board;
        logic [17:0] b;
        b = {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
        runTurn(b, 19, 1'b0, 17);
        checks++; if (wrCount !== 0) begin errors++; $display("FAIL full_writes got %0d want 0", wrCount); end
        checks++; if (busyLog[0] !== 1'b0) begin errors++; $display("FAIL full_busy0 got %b want 0", busyLog[0]); end
        for (int c = 1; c <= 17; c++) begin
            checks++;
            if (busyLog[c] !== 1'b1) begin errors++; $display("FAIL full_busy%0d got %b want 1", c, busyLog[c]); end
        end
        checks++; if (busyLog[18] !== 1'b0) begin errors++; $display("FAIL full_busy18 got %b want 0", busyLog[18]); end
    endtask

    task automatic test_timeout;
        logic [17:0] b;
        b = setCell(setCell('0, 0, MY), 1, MY);
        runTurn(b, 20, 1'b0, 18);
        checks++; if (wrCyc !== 2) begin errors++; $display("FAIL tmo_write_cycle got %0d want 2", wrCyc); end
        checks++; if (wrCount !== 1) begin errors++; $display("FAIL tmo_writes got %0d want 1", wrCount); end
        checks++; if (errLog[17] !== 1'b0) begin errors++; $display("FAIL tmo_err17 got %b want 0", errLog[17]); end
        checks++; if (errLog[18] !== 1'b1) begin errors++; $display("FAIL tmo_err18 got %b want 1", errLog[18]); end
        checks++; if (errLog[19] !== 1'b0) begin errors++; $display("FAIL tmo_err19 got %b want 0", errLog[19]); end
        checks++; if (busyLog[19] !== 1'b0) begin errors++; $display("FAIL tmo_busy19 got %b want 0", busyLog[19]); end
    endtask

    task automatic test_reset_abort;
        int wr;
        wr = 0;
        @(negedge ph1);
        gBoard = '0; gameState = TURN; enable = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge ph1);
            if (playerWrite) wr++;
            if (c == 4) reset = 1'b1;
        end
        checks++; if (playerWrite !== 1'b0) begin errors++; $display("FAIL rst_write got %b want 0", playerWrite); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (moveErr !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", moveErr); end
        checks++; if (playerInput !== 4'd0) begin errors++; $display("FAIL rst_input got %0d want 0", playerInput); end
        reset = 1'b0; gameState = 3'd0;
        repeat (25) begin @(negedge ph1); if (playerWrite) wr++; end
        checks++; if (wr !== 0) begin errors++; $display("FAIL rst_writes got %0d want 0", wr); end
    endtask

    task automatic test_enable_abort;
        int wr;
        wr = 0;
        @(negedge ph1);
        gBoard = '0; gameState = TURN; enable = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge ph1);
            busyLog[c] = busy;
            if (playerWrite) wr++;
            if (c == 12) enable = 1'b0;
        end
        checks++; if (busyLog[12] !== 1'b1) begin errors++; $display("FAIL en_busy12 got %b want 1", busyLog[12]); end
        checks++; if (busyLog[14] !== 1'b0) begin errors++; $display("FAIL en_busy14 got %b want 0", busyLog[14]); end
        checks++; if (wr !== 0) begin errors++; $display("FAIL en_writes got %0d want 0", wr); end
        gameState = 3'd0; enable = 1'b1;
    endtask

    initial begin
        test_reset;
        test_empty_centre;
        test_win_block;
        test_priority;
        test_pick_fallbacks;
        test_full_board;
        test_timeout;
        test_reset_abort;
        test_enable_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
